// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the inst/data SRAM-like port arbiter.
// Imported by the top and the starvation counter.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } grant_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Wide enough for STARVE_LIMIT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while an instruction fetch waits;
// force_inst tells the arbiter to hand the next slot to the fetch side.
module arb_starve_cnt
  import sram_like_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic idle,
  input  logic inst_req,
  input  logic grant_inst,
  input  logic grant_data,
  output logic force_inst
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             force_r;

  // Next count: clear on fetch grant or idle without a pending fetch, else saturate up.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (grant_inst) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (idle && !inst_req) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (grant_data && inst_req && (cnt_r < LIMIT_C)) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and registered limit flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r   <= {CNT_W{1'b0}};
      force_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      force_r <= (cnt_nxt_s == LIMIT_C);
    end
  end

  assign force_inst = force_r;

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: data side has priority, instruction fetch is
// forced through after STARVE_LIMIT back-to-back data grants. One transaction in flight.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  state_e            state_r;
  state_e            state_nxt_s;
  grant_e            grant_r;
  grant_e            grant_nxt_s;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              idle_s;
  logic              grant_inst_s;
  logic              grant_data_s;
  logic              force_inst_s;
  logic              done_s;

  assign idle_s = (state_r == IDLE);

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .idle       (idle_s),
    .inst_req   (inst_req),
    .grant_inst (grant_inst_s),
    .grant_data (grant_data_s),
    .force_inst (force_inst_s)
  );

  // Arbitration, only evaluated while no transaction is in flight.
  always_comb begin
    grant_data_s = 1'b0;
    grant_inst_s = 1'b0;
    if (idle_s) begin
      if (data_req && (!inst_req || !force_inst_s)) begin
        grant_data_s = 1'b1;
      end else if (inst_req) begin
        grant_inst_s = 1'b1;
      end else begin
        grant_data_s = 1'b0;
      end
    end else begin
      grant_inst_s = 1'b0;
    end
  end

  // Next state and grant.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    case (state_r)
      IDLE: begin
        if (grant_data_s) begin
          state_nxt_s = ADDR;
          grant_nxt_s = DATA;
        end else if (grant_inst_s) begin
          state_nxt_s = ADDR;
          grant_nxt_s = INST;
        end else begin
          grant_nxt_s = NONE;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          state_nxt_s = IDLE;
          grant_nxt_s = NONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = NONE;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      grant_r <= NONE;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
    end
  end

  // Request capture; bus fields come only from here so they stay stable until accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_r    <= 1'b0;
      size_r  <= 2'd0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (grant_data_s) begin
      wr_r    <= data_wr;
      size_r  <= data_size;
      addr_r  <= data_addr;
      wdata_r <= data_wdata;
    end else if (grant_inst_s) begin
      wr_r    <= 1'b0;
      size_r  <= SZ_WORD;
      addr_r  <= inst_addr;
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      wr_r    <= wr_r;
      size_r  <= size_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  assign done_s = (state_r == WAIT) && bus_data_ok;

  assign inst_addr_ok = grant_inst_s;
  assign data_addr_ok = grant_data_s;
  assign inst_data_ok = done_s && (grant_r == INST);
  assign data_data_ok = done_s && (grant_r == DATA);
  assign inst_rdata   = inst_data_ok ? bus_rdata : {DATA_W{1'b0}};
  assign data_rdata   = data_data_ok ? bus_rdata : {DATA_W{1'b0}};

  assign bus_req   = (state_r == ADDR);
  assign bus_wr    = wr_r;
  assign bus_size  = size_r;
  assign bus_addr  = addr_r;
  assign bus_wdata = wdata_r;
  assign busy      = !idle_s;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized and directed bench for sram_like_arbiter against a
// transaction-level reference model of the arbitration and completion rules.
module tb_sram_like_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk), .resetn (resetn),
    .inst_req (inst_req), .inst_addr (inst_addr),
    .inst_addr_ok (inst_addr_ok), .inst_data_ok (inst_data_ok), .inst_rdata (inst_rdata),
    .data_req (data_req), .data_wr (data_wr), .data_size (data_size),
    .data_addr (data_addr), .data_wdata (data_wdata),
    .data_addr_ok (data_addr_ok), .data_data_ok (data_data_ok), .data_rdata (data_rdata),
    .bus_req (bus_req), .bus_wr (bus_wr), .bus_size (bus_size),
    .bus_addr (bus_addr), .bus_wdata (bus_wdata),
    .bus_addr_ok (bus_addr_ok), .bus_data_ok (bus_data_ok), .bus_rdata (bus_rdata),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one in-flight transaction record plus the data-grant streak.
  bit        m_busy;
  bit        m_sent;
  bit        m_data_side;
  bit        m_wr;
  bit [1:0]  m_size;
  bit [31:0] m_addr;
  bit [31:0] m_wdata;
  int        m_streak;

  bit g_inst;
  bit g_data;
  int n_data_gnt;
  int n_inst_gnt;
  int last_gnt;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_sent = 1'b0; m_data_side = 1'b0; m_wr = 1'b0;
    m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0; m_streak = 0;
  endtask

  // Check one cycle's outputs against the model, advance the model, move to next negedge.
  task automatic tick();
    bit dw, iw, done;
    #1;
    g_inst = 1'b0;
    g_data = 1'b0;
    if (!resetn) begin
      check("rst_req_side", {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata}, 72'd0);
      check("rst_bus_side", {bus_req, bus_wr, bus_size, bus_addr, bus_wdata, busy}, 72'd0);
      model_reset();
    end else begin
      dw   = !m_busy && data_req && (!inst_req || m_streak < LIM);
      iw   = !m_busy && !dw && inst_req;
      done = m_busy && m_sent && bus_data_ok;
      check("inst_addr_ok", inst_addr_ok, iw);
      check("data_addr_ok", data_addr_ok, dw);
      check("inst_data_ok", inst_data_ok, done && !m_data_side);
      check("data_data_ok", data_data_ok, done && m_data_side);
      check("inst_rdata", inst_rdata, (done && !m_data_side) ? bus_rdata : 32'd0);
      check("data_rdata", data_rdata, (done && m_data_side) ? bus_rdata : 32'd0);
      check("bus_req", bus_req, m_busy && !m_sent);
      check("busy", busy, m_busy);
      if (m_busy && !m_sent) begin
        check("bus_fields", {bus_wr, bus_size, bus_addr, bus_wdata}, {m_wr, m_size, m_addr, m_wdata});
      end
      if (iw) m_streak = 0;
      else if (!m_busy && !inst_req) m_streak = 0;
      else if (dw && inst_req && m_streak < LIM) m_streak++;
      if (dw) begin
        m_busy = 1'b1; m_sent = 1'b0; m_data_side = 1'b1;
        m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
        g_data = 1'b1; n_data_gnt++; last_gnt = 1;
      end else if (iw) begin
        m_busy = 1'b1; m_sent = 1'b0; m_data_side = 1'b0;
        m_wr = 1'b0; m_size = 2'd2; m_addr = inst_addr; m_wdata = 32'd0;
        g_inst = 1'b1; n_inst_gnt++; last_gnt = 2;
      end else if (m_busy && !m_sent && bus_addr_ok) begin
        m_sent = 1'b1;
      end else if (done) begin
        m_busy = 1'b0; m_sent = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Lone fetch: accept at cycle 0, bus accepts at 1, data returns at 3.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    #1 check("lone_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; inst_addr = 32'h1234_5678; bus_addr_ok = 1'b1;
    #1 check("lone_inst_bus", {bus_req, bus_wr, bus_addr}, {1'b1, 1'b0, 32'hBFC0_0000});
    tick();
    bus_addr_ok = 1'b0;
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h3C08_8000;
    #1 check("lone_inst_data", {inst_data_ok, inst_rdata, data_data_ok}, {1'b1, 32'h3C08_8000, 1'b0});
    tick();
    bus_data_ok = 1'b0;

    // Simultaneous store and fetch; then bus stalls address acceptance 5 cycles.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    #1 check("both_data_first", {data_addr_ok, inst_addr_ok}, {1'b1, 1'b0});
    tick();
    data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_addr = $urandom; data_wdata = $urandom; data_wr = 1'b0;
      #1 check("stall_bus_hold", {bus_req, bus_wr, bus_addr, bus_wdata}, {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF});
      tick();
    end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0;
    tick();
    bus_data_ok = 1'b0;
    #1 check("inst_after_data", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = $urandom;
    tick();

    // Spurious completion while idle.
    for (int i = 0; i < 2; i++) begin
      bus_rdata = $urandom;
      tick();
    end
    bus_data_ok = 1'b0;

    // Starvation guard: both held high, bus always ready.
    n_data_gnt = 0; n_inst_gnt = 0;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    for (int k = 0; k < 60 && n_inst_gnt == 0; k++) tick();
    check("starve_data_grants", n_data_gnt, LIM);
    check("starve_inst_grants", n_inst_gnt, 1);
    for (int k = 0; k < 10 && n_data_gnt == LIM; k++) tick();
    check("starve_cleared_next", last_gnt, 1);
    inst_req = 1'b0; data_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // Reset while waiting for data; later completion must be ignored.
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #1 check("post_rst_ignore", {inst_data_ok, data_data_ok, busy}, 3'd0);
    tick();
    bus_data_ok = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (inst_req && g_inst) inst_req = ($urandom_range(1, 0) == 1);
      else if (inst_req) inst_req = ($urandom_range(15, 0) != 0);
      else inst_req = ($urandom_range(2, 0) == 0);
      if (data_req && g_data) data_req = ($urandom_range(1, 0) == 1);
      else if (data_req) data_req = ($urandom_range(15, 0) != 0);
      else data_req = ($urandom_range(2, 0) == 0);
      inst_addr   = $urandom;
      data_wr     = $urandom_range(1, 0);
      data_size   = 2'($urandom_range(2, 0));
      data_addr   = $urandom;
      data_wdata  = $urandom;
      bus_addr_ok = ($urandom_range(1, 0) == 1);
      bus_data_ok = ($urandom_range(4, 0) < 2);
      bus_rdata   = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
